// File: rtl/lock_access_ctrl_pkg.sv
// Shared constants for the lock access controller: state encoding and
// default window lengths used by the top level and its interface.
package lock_ctrl_pkg;

  localparam int PIN_LEN_DEF        = 3;
  localparam int ENTRY_TIMEOUT_DEF  = 8;
  localparam int UNLOCK_CYCLES_DEF  = 16;
  localparam int MAX_FAILS_DEF      = 3;
  localparam int LOCKOUT_CYCLES_DEF = 32;

  localparam logic [2:0] CLR     = 3'd0;
  localparam logic [2:0] IDLE    = 3'd1;
  localparam logic [2:0] ENTRY   = 3'd2;
  localparam logic [2:0] EVAL    = 3'd3;
  localparam logic [2:0] OPEN    = 3'd4;
  localparam logic [2:0] LOCKOUT = 3'd5;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lock_access_ctrl_if.sv
// Keypad, checker and door-side signals of the lock access controller.
// slave = the controller, master = its surroundings (keypad, checker, door).
interface lock_access_ctrl_if #(
  parameter int MAX_FAILS = lock_ctrl_pkg::MAX_FAILS_DEF
);
  logic key0;
  logic key1;
  logic lock_req;
  logic chk_unlocked;
  logic chk_w0;
  logic chk_w1;
  logic chk_rst_n;
  logic door_open;
  logic lockout;
  logic attempt_fail;
  logic [$clog2(MAX_FAILS+1)-1:0] fail_cnt;

  modport slave (
    input  key0, key1, lock_req, chk_unlocked,
    output chk_w0, chk_w1, chk_rst_n, door_open, lockout, fail_cnt, attempt_fail
  );

  modport master (
    output key0, key1, lock_req, chk_unlocked,
    input  chk_w0, chk_w1, chk_rst_n, door_open, lockout, fail_cnt, attempt_fail
  );
endinterface

// File: rtl/lock_access_ctrl_timer.sv
// Cycle counter shared by the ENTRY, OPEN and LOCKOUT windows; done is
// asserted combinationally while the count equals the selected limit.
module lock_cycle_timer #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             done
);
  logic [WIDTH-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset)       count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + WIDTH'(1);
  end

  assign done = (count == limit);
endmodule

// File: rtl/lock_access_ctrl.sv
// Access controller sequencing the external PIN checker: key forwarding,
// door-open window, failure counting and lockout. Optional macro
// LOCK_TIMEOUT_IS_FAIL_EN makes an ENTRY timeout count as a failed attempt.
module lock_access_ctrl
  import lock_ctrl_pkg::*;
#(
  parameter int PIN_LEN        = PIN_LEN_DEF,
  parameter int ENTRY_TIMEOUT  = ENTRY_TIMEOUT_DEF,
  parameter int UNLOCK_CYCLES  = UNLOCK_CYCLES_DEF,
  parameter int MAX_FAILS      = MAX_FAILS_DEF,
  parameter int LOCKOUT_CYCLES = LOCKOUT_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                reset,
  lock_access_ctrl_if.slave   bus
);
  localparam int TW = $clog2(max3(ENTRY_TIMEOUT, UNLOCK_CYCLES, LOCKOUT_CYCLES) + 1);
  localparam int PW = $clog2(PIN_LEN + 1);
  localparam int FW = $clog2(MAX_FAILS + 1);

  logic [2:0]    state, next_state;
  logic [PW-1:0] press_cnt;
  logic          bad_flag;
  logic [FW-1:0] fail_cnt, fail_inc;
  logic          accept, press, fail_now;
  logic          timer_clear, timer_en, timer_done;
  logic [TW-1:0] timer_limit;

  assign accept     = (state == IDLE) || (state == ENTRY);
  assign press      = accept & (bus.key0 | bus.key1);
  assign bus.chk_w0 = accept & bus.key0 & ~bus.key1;
  assign bus.chk_w1 = accept & bus.key1 & ~bus.key0;
  assign fail_inc   = (fail_cnt == FW'(MAX_FAILS)) ? fail_cnt : fail_cnt + FW'(1);

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    next_state  = state;
    fail_now    = 1'b0;
    timer_limit = TW'(ENTRY_TIMEOUT - 1);
    case (state)
      CLR:  next_state = IDLE;
      IDLE: if (press) next_state = (PIN_LEN == 1) ? EVAL : ENTRY;
      ENTRY: begin
        if (press) begin
          if (press_cnt == PW'(PIN_LEN - 1)) next_state = EVAL;
        end else if (timer_done) begin
`ifdef LOCK_TIMEOUT_IS_FAIL_EN
          fail_now   = 1'b1;
          next_state = (fail_inc == FW'(MAX_FAILS)) ? LOCKOUT : CLR;
`else
          next_state = CLR;
`endif
        end
      end
      EVAL: begin
        if (bus.chk_unlocked && !bad_flag) begin
          next_state = OPEN;
        end else begin
          fail_now   = 1'b1;
          next_state = (fail_inc == FW'(MAX_FAILS)) ? LOCKOUT : CLR;
        end
      end
      OPEN: begin
        timer_limit = TW'(UNLOCK_CYCLES - 1);
        if (bus.lock_req || timer_done) next_state = CLR;
      end
      LOCKOUT: begin
        timer_limit = TW'(LOCKOUT_CYCLES - 1);
        if (timer_done) next_state = CLR;
      end
      default: next_state = CLR;
    endcase
  end

  // The window timer restarts on every state change and on each key press.
  assign timer_clear = (next_state != state) || ((state == ENTRY) && press);
  assign timer_en    = (state == ENTRY) || (state == OPEN) || (state == LOCKOUT);

  lock_cycle_timer #(.WIDTH(TW)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (timer_en),
    .limit  (timer_limit),
    .done   (timer_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= CLR;
      bus.chk_rst_n    <= 1'b0;
      bus.door_open    <= 1'b0;
      bus.lockout      <= 1'b0;
      bus.attempt_fail <= 1'b0;
      fail_cnt         <= '0;
      press_cnt        <= '0;
      bad_flag         <= 1'b0;
    end else begin
      state            <= next_state;
      bus.chk_rst_n    <= (next_state != CLR);
      bus.door_open    <= (next_state == OPEN);
      bus.lockout      <= (next_state == LOCKOUT);
      bus.attempt_fail <= fail_now;

      if (fail_now)
        fail_cnt <= fail_inc;
      else if ((state == EVAL && next_state == OPEN) || (state == LOCKOUT && next_state == CLR))
        fail_cnt <= '0;

      if (state == CLR) begin
        press_cnt <= '0;
        bad_flag  <= 1'b0;
      end else if (press) begin
        press_cnt <= (state == IDLE) ? PW'(1) : press_cnt + PW'(1);
        if (bus.key0 && bus.key1) bad_flag <= 1'b1;
      end
    end
  end

  assign bus.fail_cnt = fail_cnt;
endmodule
